// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and execute-side update signals of the branch predictor,
// bundled so the pipeline (master) and the predictor (slave) share one port.
interface branch_predictor_if;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_pc;

  modport master (
    output pc_f, upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_pc,
    input  pred_taken_f, pred_pc_f
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_jump, upd_taken, upd_target,
           upd_pred_taken, upd_pred_pc,
    output pred_taken_f, pred_pc_f
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters; combinational lookup, registered update.
// Define BP_STATS_EN to add the stat_updates / stat_mispred counters.
module branch_predictor #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  branch_predictor_if.slave   bus
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispred
`endif
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0] valid_q;
  logic [1:0]         ctr_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];

  // Lookup: reads the current (pre-update) contents, no bypass.
  logic [IDX_W-1:0] f_idx;
  logic [TAG_W-1:0] f_tag;
  logic             f_hit;

  assign f_idx = bus.pc_f[IDX_W+1:2];
  assign f_tag = bus.pc_f[IDX_W+TAG_W+1:IDX_W+2];
  assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

  assign bus.pred_taken_f = f_hit && ctr_q[f_idx][1];
  assign bus.pred_pc_f    = bus.pred_taken_f ? target_q[f_idx] : bus.pc_f + 32'd4;

  // Update decision
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  logic             wr_en;
  logic [1:0]       new_ctr;
  logic [31:0]      new_target;

  assign u_idx = bus.upd_pc[IDX_W+1:2];
  assign u_tag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    wr_en      = 1'b0;
    new_ctr    = ctr_q[u_idx];
    new_target = target_q[u_idx];
    if (bus.upd_valid) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (bus.upd_jump) begin
          new_ctr    = 2'b11;
          new_target = bus.upd_target;
        end else if (bus.upd_taken) begin
          if (ctr_q[u_idx] != 2'b11) new_ctr = ctr_q[u_idx] + 2'd1;
          new_target = bus.upd_target;
        end else begin
          if (ctr_q[u_idx] != 2'b00) new_ctr = ctr_q[u_idx] - 2'd1;
        end
      end else if (bus.upd_taken) begin
        wr_en      = 1'b1;
        new_ctr    = bus.upd_jump ? 2'b11 : 2'b10;
        new_target = bus.upd_target;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b00;
    end else if (wr_en) begin
      valid_q[u_idx] <= 1'b1;
      ctr_q[u_idx]   <= new_ctr;
    end
  end

  // NOTE: tags and targets are qualified by valid, so this storage needs no reset.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= new_target;
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.upd_pc[31:IDX_W+TAG_W+2], bus.upd_pc[1:0]};

`ifdef BP_STATS_EN
  logic mispred;
  assign mispred = bus.upd_valid &&
                   ((bus.upd_pred_taken != bus.upd_taken) ||
                    (bus.upd_taken && (bus.upd_pred_pc != bus.upd_target)));

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_updates <= '0;
      stat_mispred <= '0;
    end else begin
      if (bus.upd_valid && (stat_updates != 32'hFFFF_FFFF)) stat_updates <= stat_updates + 32'd1;
      if (mispred && (stat_mispred != 32'hFFFF_FFFF))       stat_mispred <= stat_mispred + 32'd1;
    end
  end
`else
  logic unused_stats_inputs;
  assign unused_stats_inputs = ^{bus.upd_pred_taken, bus.upd_pred_pc};
`endif

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter IDX_W, default 4, meaning table index width; the table holds 2^IDX_W entries.
REQ-002 Parameter TAG_W, default 8, meaning tag width; the tag is pc[IDX_W+TAG_W+1 : IDX_W+2].
REQ-003 clk  input  1  meaning the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  meaning reset, synchronous and active-low (0 = reset).
REQ-005 pc_f  input  32  meaning fetch-stage PC to predict for.
REQ-006 pred_taken_f  output  1  meaning predicted taken for pc_f; feeds pred_taken_d through the fetch register.
REQ-007 pred_pc_f  output  32  meaning predicted next PC; feeds pred_pc_d.
REQ-008 upd_valid  input  1  meaning a resolved branch or jump is in execute this cycle.
REQ-009 upd_pc  input  32  meaning PC of the resolved instruction (pc_e1).
REQ-010 upd_jump  input  1  meaning the resolved instruction is a jump (jump_e1).
REQ-011 upd_taken  input  1  meaning actual outcome is taken.
REQ-012 upd_target  input  32  meaning actual taken target.
REQ-013 upd_pred_taken  input  1  meaning the prediction carried down the pipe (pred_taken_e1).
REQ-014 upd_pred_pc  input  32  meaning the predicted PC carried down the pipe (pred_pc_e1).

Function
REQ-015 Each entry holds: valid (1b), tag (TAG_W), target (32b) and a 2-bit counter (00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
REQ-016 Lookup is combinational from pc_f, with zero cycles latency: index pc_f[IDX_W+1:2]; hit = valid and tag equal.
REQ-017 pred_taken_f = hit and counter[1]; pred_pc_f = pred_taken_f ? entry target : pc_f+4, with 32-bit wrap (0xFFFFFFFC+4 = 0x0).
REQ-018 Update is registered at the posedge when upd_valid=1 and rst=1; when upd_valid=0 no state changes.
REQ-019 Update hit, branch: the counter saturating-increments if taken and saturating-decrements if not (no wrap past 00 or 11); the target is overwritten with upd_target if taken.
REQ-020 Update hit, jump: the counter is set to 11 and the target is overwritten.
REQ-021 Update miss, taken: the entry is allocated (overwriting any other tag at that index); valid=1, tag and target written; counter = 11 for jump, 10 for branch.
REQ-022 Update miss, not taken: no allocation and no state change.
REQ-023 Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents, with no bypass; the new contents are visible from the next cycle.
REQ-024 Mispredict = upd_valid and ((upd_pred_taken != upd_taken) or (upd_taken and upd_pred_pc != upd_target)); used only by the statistics option.

Reset
REQ-025 While rst=0 at a posedge, all valid bits and all counters clear to 0 (counter 00); tags and targets are don't-care.
REQ-026 Reset has priority over a simultaneous update; that update is discarded.
REQ-027 During and after reset, pred_taken_f=0 and pred_pc_f=pc_f+4 until a taken update allocates an entry.

Configuration
REQ-028 The macro BP_STATS_EN controls the statistics counters.
REQ-029 When BP_STATS_EN is defined, the module adds two outputs: stat_updates (32b), counting cycles with upd_valid=1, and stat_mispred (32b), counting mispredicts.
REQ-030 Both statistics counters saturate at 0xFFFFFFFF and clear on reset.
REQ-031 When BP_STATS_EN is undefined, the statistics ports and logic are absent, and prediction behaviour is identical to the defined case.

Verification
REQ-032 Reset, then pc_f=0x100 -> pred_taken_f=0 and pred_pc_f=0x104.
REQ-033 Branch update at 0x100, taken, target 0x40 -> the next cycle pc_f=0x100 gives pred_taken_f=1, pred_pc_f=0x40; then two not-taken updates -> pred_taken_f=0 (counter 00).
REQ-034 Five taken updates at 0x200, then one not-taken -> counter 10 and still predicts taken; a second not-taken -> counter 01 and predicts not taken.
REQ-035 Entry at 0x100, then a taken jump at 0x1100 (same index, different tag), target 0x80 -> 0x100 misses (pred_pc_f=0x104) and 0x1100 predicts 0x80.
REQ-036 Update and lookup of 0x300 in the same cycle on an empty table -> that cycle pred_taken_f=0; the next cycle pred_taken_f=1.
REQ-037 With BP_STATS_EN: 3 updates, one with upd_pred_taken=0 and upd_taken=1 -> stat_updates=3, stat_mispred=1; assert rst=0 -> both read 0.
